// File: rtl/seq_pattern_gen.sv
// Purpose : serial pattern transmitter, WIDTH-bit pattern MSB-first, repeated rep_cnt+1 times.
// Latency : first bit on x on the same edge that accepts start; one bit per clock, no gaps.
// Backpr. : none; start is ignored while busy or in DONE, abort ends a run with no done pulse.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   start, abort        run request (IDLE only) / synchronous abort (SHIFT only)
//   pattern, rep_cnt    pattern bits and extra repetitions, sampled when start is accepted
//   x, x_valid          registered serial bit and its qualifier
//   busy, done          high in SHIFT / one-cycle pulse after the final bit
//   exp_hits            overlapping "11" count, only when SEQ_GEN_HITS_EN is defined
module seq_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
`ifdef SEQ_GEN_HITS_EN
  , parameter int HIT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [REP_W-1:0] rep_cnt,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
`ifdef SEQ_GEN_HITS_EN
  , output logic [HIT_W-1:0] exp_hits
`endif
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  // sreg_q holds the bits still to be shown; its MSB is the next bit for x.
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             x_d, xv_d, busy_d, done_d;
`ifdef SEQ_GEN_HITS_EN
  logic [HIT_W-1:0] hits_d;
`endif

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    sreg_d  = sreg_q;
    rep_d   = rep_q;
    idx_d   = idx_q;
    x_d     = 1'b0;
    xv_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef SEQ_GEN_HITS_EN
    hits_d  = exp_hits;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          pat_d   = pattern;
          rep_d   = rep_cnt;
          idx_d   = '0;
          x_d     = pattern[WIDTH-1];
          sreg_d  = {pattern[WIDTH-2:0], 1'b0};
          xv_d    = 1'b1;
          busy_d  = 1'b1;
`ifdef SEQ_GEN_HITS_EN
          hits_d  = '0;
`endif
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (idx_q == LAST) begin
          if (rep_q != '0) begin
            // Wrap straight back to the MSB of the latched pattern: no gap cycle.
            rep_d  = rep_q - REP_W'(1);
            idx_d  = '0;
            x_d    = pat_q[WIDTH-1];
            sreg_d = {pat_q[WIDTH-2:0], 1'b0};
            xv_d   = 1'b1;
            busy_d = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          idx_d  = idx_q + IW'(1);
          x_d    = sreg_q[WIDTH-1];
          sreg_d = sreg_q << 1;
          xv_d   = 1'b1;
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef SEQ_GEN_HITS_EN
    // x still holds the previous bit of this run while a next bit is being emitted.
    if (state_q == SHIFT && xv_d && x_d && x && (exp_hits != '1)) begin
      hits_d = exp_hits + HIT_W'(1);
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      sreg_q  <= '0;
      rep_q   <= '0;
      idx_q   <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      sreg_q  <= sreg_d;
      rep_q   <= rep_d;
      idx_q   <= idx_d;
      x       <= x_d;
      x_valid <= xv_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

`ifdef SEQ_GEN_HITS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_hits <= '0;
    end else begin
      exp_hits <= hits_d;
    end
  end
`endif

endmodule
